// File: rtl/serializador.sv
// Transmit serializer: pops one byte from the queue and shifts it out as a framed
// WIDTH-bit serial word, then enforces an idle gap before the next frame.
module serializador #(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 2,
  parameter int DEQ_HOLD   = 1
) (
  input  logic             clock_100KHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             ready_in,
  output logic             dequeue_out,
  output logic             data_out,
  output logic             write_out,
  output logic             status_out,
  output logic [7:0]       tx_count
);

  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int HOLD_W = $clog2(DEQ_HOLD + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [7:0]         tx_q, tx_d;
  logic               deq_q, deq_d;
  logic               dout_q, dout_d;
  logic               wr_q, wr_d;
  logic               stat_q, stat_d;
  logic               headBit;
  logic [WIDTH-1:0]   shiftNext;

  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      tx_q    <= '0;
      deq_q   <= 1'b0;
      dout_q  <= 1'b0;
      wr_q    <= 1'b0;
      stat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      deq_q   <= deq_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      stat_q  <= stat_d;
    end
  end

  // The bit about to leave is always at the head end; shifting pulls the next one in.
  assign headBit   = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];
  assign shiftNext = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    tx_d    = tx_q;
    deq_d   = deq_q;
    dout_d  = dout_q;
    wr_d    = wr_q;
    stat_d  = stat_q;
    unique case (state_q)
      IDLE: begin
        deq_d  = 1'b0;
        dout_d = 1'b0;
        wr_d   = 1'b0;
        stat_d = 1'b0;
        if ((len_in != '0) && ready_in) begin
          shift_d = data_in;
          deq_d   = 1'b1;
          stat_d  = 1'b1;
          hold_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (hold_q == HOLD_W'(DEQ_HOLD - 1)) begin
          deq_d   = 1'b0;
          dout_d  = headBit;
          shift_d = shiftNext;
          wr_d    = 1'b1;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      SHIFT: begin
        if (bit_q == BIT_W'(WIDTH - 1)) begin
          wr_d    = 1'b0;
          dout_d  = 1'b0;
          tx_d    = tx_q + 8'd1;
          bit_d   = '0;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          bit_d   = bit_q + 1'b1;
          dout_d  = headBit;
          shift_d = shiftNext;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          stat_d  = 1'b0;
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dequeue_out = deq_q;
  assign data_out    = dout_q;
  assign write_out   = wr_q;
  assign status_out  = stat_q;
  assign tx_count    = tx_q;

endmodule

// File: tb/tb_serializador.sv
// Directed bench for serializador: default instance plus an LSB-first, long-pop instance.
module tb_serializador;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] dataIn, dataIn2;
  logic [3:0] lenIn, lenIn2;
  logic       readyIn, readyIn2;
  logic       deq, dout, wout, stat;
  logic       deq2, dout2, wout2, stat2;
  logic [7:0] txc, txc2;

  int         total = 0;
  int         bad = 0;
  logic [7:0] fifo[$];
  bit         autoQ = 0;
  logic       deqPrev = 1'b0;

  serializador dut (
    .clock_100KHz(clk), .reset(rstN), .data_in(dataIn), .len_in(lenIn),
    .ready_in(readyIn), .dequeue_out(deq), .data_out(dout), .write_out(wout),
    .status_out(stat), .tx_count(txc)
  );

  serializador #(.MSB_FIRST(0), .DEQ_HOLD(3)) dut2 (
    .clock_100KHz(clk), .reset(rstN), .data_in(dataIn2), .len_in(lenIn2),
    .ready_in(readyIn2), .dequeue_out(deq2), .data_out(dout2), .write_out(wout2),
    .status_out(stat2), .tx_count(txc2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [3:0] l, input logic r);
    dataIn  = d;
    lenIn   = l;
    readyIn = r;
  endtask

  // Advance one edge and sample just after it; the optional queue model pops on each new dequeue pulse.
  task automatic stepClock();
    @(posedge clk);
    #1;
    if (autoQ) begin
      if (deq && !deqPrev && fifo.size() > 0) void'(fifo.pop_front());
      lenIn  = 4'(fifo.size());
      dataIn = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
    deqPrev = deq;
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    repeat (2) stepClock();
    rstN = 1'b1;
  endtask

  initial begin
    int         zerosBetween;
    int         framesSeen;
    int         frames;
    bit         seen255;
    logic [7:0] f1, f2, bits, expA5;
    logic       prevW;

    // T1: reset held with a non-empty queue and ready receiver
    rstN = 1'b0;
    applyStimulus(8'h55, 4'd3, 1'b1);
    dataIn2 = 8'h00; lenIn2 = 4'd0; readyIn2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput("rst_deq", deq, 1'b0);
      checkOutput("rst_wr", wout, 1'b0);
      checkOutput("rst_dout", dout, 1'b0);
      checkOutput("rst_stat", stat, 1'b0);
      checkOutput("rst_txc", txc, 8'd0);
    end
    applyStimulus(8'h55, 4'd0, 1'b1);
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput("empty_deq", deq, 1'b0);
      checkOutput("empty_stat", stat, 1'b0);
    end

    // T2: single byte A5, MSB first
    fifo.push_back(8'hA5);
    autoQ = 1;
    lenIn = 4'd1;
    dataIn = 8'hA5;
    stepClock();
    checkOutput("t2_launch_deq", deq, 1'b1);
    checkOutput("t2_launch_wr", wout, 1'b0);
    checkOutput("t2_launch_stat", stat, 1'b1);
    expA5 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      stepClock();
      checkOutput("t2_deq", deq, 1'b0);
      checkOutput("t2_wr", wout, 1'b1);
      checkOutput($sformatf("t2_bit%0d", i), dout, expA5[7-i]);
    end
    stepClock();
    checkOutput("t2_end_wr", wout, 1'b0);
    checkOutput("t2_end_dout", dout, 1'b0);
    checkOutput("t2_txc", txc, 8'd1);
    checkOutput("t2_gap_stat", stat, 1'b1);
    stepClock();
    checkOutput("t2_gap2_stat", stat, 1'b1);
    stepClock();
    checkOutput("t2_idle_stat", stat, 1'b0);
    stepClock();
    checkOutput("t2_nodeq", deq, 1'b0);

    // T3: backpressure with two bytes waiting
    autoQ = 0;
    applyStimulus(8'h5A, 4'd2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      stepClock();
      checkOutput("t3_bp_deq", deq, 1'b0);
      checkOutput("t3_bp_wr", wout, 1'b0);
    end
    readyIn = 1'b1;
    stepClock();
    checkOutput("t3_start_deq", deq, 1'b1);
    applyStimulus(8'h5A, 4'd0, 1'b1);
    stepClock();
    checkOutput("t3_first_bit", dout, 1'b0);
    checkOutput("t3_first_wr", wout, 1'b1);
    repeat (10) stepClock();
    checkOutput("t3_txc", txc, 8'd2);
    checkOutput("t3_idle", stat, 1'b0);

    // T4: back-to-back 01 then FF
    applyReset();
    fifo.push_back(8'h01);
    fifo.push_back(8'hFF);
    autoQ = 1;
    lenIn = 4'd2;
    dataIn = 8'h01;
    readyIn = 1'b1;
    zerosBetween = 0; framesSeen = 0; f1 = 8'h00; f2 = 8'h00; prevW = 1'b0;
    for (int i = 0; i < 60; i++) begin
      stepClock();
      if (wout && !prevW) framesSeen++;
      if (wout) begin
        if (framesSeen == 1) f1 = {f1[6:0], dout};
        else if (framesSeen == 2) f2 = {f2[6:0], dout};
      end else if (framesSeen == 1) begin
        zerosBetween++;
      end
      prevW = wout;
    end
    checkOutput("t4_frames", framesSeen, 2);
    checkOutput("t4_frame1", f1, 8'h01);
    checkOutput("t4_frame2", f2, 8'hFF);
    checkOutput("t4_idle_between", zerosBetween, 4);
    checkOutput("t4_txc", txc, 8'd2);
    checkOutput("t4_deq_idle", deq, 1'b0);

    // T5: mid-frame ready drop and data change, then reset mid-frame
    autoQ = 0;
    applyStimulus(8'h3C, 4'd1, 1'b1);
    stepClock();
    checkOutput("t5_launch", deq, 1'b1);
    bits = 8'h00;
    for (int i = 0; i < 8; i++) begin
      stepClock();
      bits = {bits[6:0], dout};
      if (i == 3) begin
        readyIn = 1'b0;
        dataIn = 8'hC3;
      end
    end
    checkOutput("t5_frame", bits, 8'h3C);
    repeat (3) stepClock();
    checkOutput("t5_txc", txc, 8'd3);
    checkOutput("t5_idle", stat, 1'b0);
    applyStimulus(8'hAA, 4'd1, 1'b1);
    stepClock();
    checkOutput("t5_launch2", deq, 1'b1);
    repeat (6) stepClock();
    checkOutput("t5_pre_rst_wr", wout, 1'b1);
    rstN = 1'b0;
    #1;
    checkOutput("t5_rst_wr", wout, 1'b0);
    checkOutput("t5_rst_dout", dout, 1'b0);
    checkOutput("t5_rst_stat", stat, 1'b0);
    checkOutput("t5_rst_txc", txc, 8'd0);
    applyStimulus(8'h00, 4'd0, 1'b0);
    rstN = 1'b1;
    stepClock();
    checkOutput("t5_after_rst", stat, 1'b0);

    // T6a: 256 frames wrap the frame counter
    applyStimulus(8'h5A, 4'd1, 1'b1);
    frames = 0; seen255 = 0; prevW = 1'b0;
    for (int i = 0; i < 4000 && frames < 256; i++) begin
      stepClock();
      if (prevW && !wout) begin
        frames++;
        if (frames == 255) begin
          seen255 = 1;
          checkOutput("t6_txc255", txc, 8'd255);
        end
      end
      prevW = wout;
    end
    lenIn = 4'd0;
    checkOutput("t6_frames", frames, 256);
    checkOutput("t6_seen255", seen255, 1);
    checkOutput("t6_wrap", txc, 8'd0);
    repeat (4) stepClock();
    checkOutput("t6_idle", stat, 1'b0);

    // T6b: LSB-first instance with three-cycle pop
    dataIn2 = 8'h80; lenIn2 = 4'd1; readyIn2 = 1'b1;
    stepClock();
    lenIn2 = 4'd0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t6b_deq%0d", i), deq2, 1'b1);
      checkOutput("t6b_load_wr", wout2, 1'b0);
      stepClock();
    end
    bits = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checkOutput("t6b_deq_low", deq2, 1'b0);
      checkOutput("t6b_wr", wout2, 1'b1);
      checkOutput($sformatf("t6b_bit%0d", i), dout2, (i == 7) ? 1'b1 : 1'b0);
      stepClock();
    end
    checkOutput("t6b_end_wr", wout2, 1'b0);
    checkOutput("t6b_txc", txc2, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
